// File: rtl/planificador_acciones_pkg.sv
// Shared definitions for the action scheduler: action codes, FSM states,
// button indices and the small helpers used to walk the round-robin order.
package planificador_acciones_pkg;

  localparam logic [1:0] ACC_NADA   = 2'b00;
  localparam logic [1:0] ACC_COMER  = 2'b01;
  localparam logic [1:0] ACC_JUGAR  = 2'b10;
  localparam logic [1:0] ACC_DORMIR = 2'b11;

  localparam logic [1:0] NIVEL_LLENO = 2'd3;

  // Bit positions of each button inside the pending-request vector
  localparam logic [1:0] BOT_COMIDA = 2'd0;
  localparam logic [1:0] BOT_JUGAR  = 2'd1;
  localparam logic [1:0] BOT_DORMIR = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DORMIDO  = 2'd2
  } estado_t;

  // Next button in the round-robin ring comida -> jugar -> dormir -> comida
  function automatic logic [1:0] siguiente(input logic [1:0] idx);
    return (idx == BOT_DORMIR) ? BOT_COMIDA : idx + 2'd1;
  endfunction

  // Action code presented to the pet FSM for a given button index
  function automatic logic [1:0] codigo_accion(input logic [1:0] idx);
    case (idx)
      BOT_COMIDA: return ACC_COMER;
      BOT_JUGAR:  return ACC_JUGAR;
      BOT_DORMIR: return ACC_DORMIR;
      default:    return ACC_NADA;
    endcase
  endfunction

endpackage

// File: rtl/planificador_acciones_sincronizador_flanco.sv
// Two-flop synchronizer for an asynchronous button level followed by a
// rising-edge detector; the pulse lasts one clock cycle.
module sincronizador_flanco (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic flanco
);

  logic sinc_p0;
  logic sinc_p1;
  logic sinc_p2;

  // Metastability chain plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sinc_p0 <= 1'b0;
      sinc_p1 <= 1'b0;
      sinc_p2 <= 1'b0;
    end else begin
      sinc_p0 <= entrada;
      sinc_p1 <= sinc_p0;
      sinc_p2 <= sinc_p1;
    end
  end

  assign flanco = sinc_p1 & ~sinc_p2;

endmodule

// File: rtl/planificador_acciones.sv
// Action scheduler in front of the pet FSM: latches button requests, grants
// them round-robin over valid/ready, generates the decay tick and enforces
// the sleep lockout and the full-level feed discard.
module planificador_acciones
  import planificador_acciones_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int SLEEP_TICKS = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_comida,
  input  logic       boton_jugar,
  input  logic       boton_dormir,
  input  logic [1:0] nivel,
  input  logic       accion_listo,
  output logic       accion_valida,
  output logic [1:0] accion,
  output logic       tick_decaimiento,
  output logic       dormido,
  output logic       descartado,
  output logic       error_timeout
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SLEEP_TICKS + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_FIN = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SL_FIN   = SW'(SLEEP_TICKS - 1);
  localparam logic [AW-1:0] TO_FIN   = AW'(ACK_TIMEOUT - 1);

  estado_t       estado, estado_n;
  logic [2:0]    flancos;
  logic [2:0]    pend, pend_n;
  logic [1:0]    ptr, ptr_n;
  logic [1:0]    conc, conc_n;
  logic [SW-1:0] sl_cnt, sl_n;
  logic [AW-1:0] to_cnt, to_n;
  logic [TW-1:0] tick_cnt;
  logic          valida_n;
  logic [1:0]    accion_n;
  logic          descartado_n;
  logic          error_n;
  logic          hallado;
  logic [1:0]    ganador;
  logic [1:0]    cand;

  sincronizador_flanco u_sinc_comida (
    .clk(clk), .reset(reset), .entrada(boton_comida), .flanco(flancos[BOT_COMIDA])
  );
  sincronizador_flanco u_sinc_jugar (
    .clk(clk), .reset(reset), .entrada(boton_jugar), .flanco(flancos[BOT_JUGAR])
  );
  sincronizador_flanco u_sinc_dormir (
    .clk(clk), .reset(reset), .entrada(boton_dormir), .flanco(flancos[BOT_DORMIR])
  );

  // Free-running decay time base, independent of the FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_decaimiento) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick_decaimiento = (tick_cnt == TICK_FIN);
  assign dormido          = (estado == DORMIDO);

  // Next-state logic: request latching, arbitration, handshake and lockout
  always_comb begin
    estado_n     = estado;
    pend_n       = pend;
    ptr_n        = ptr;
    conc_n       = conc;
    sl_n         = sl_cnt;
    to_n         = to_cnt;
    valida_n     = accion_valida;
    accion_n     = accion;
    descartado_n = 1'b0;
    error_n      = error_timeout;
    hallado      = 1'b0;
    ganador      = BOT_COMIDA;
    cand         = ptr;

    // New presses are dropped while asleep; already-pending bits survive
    if (estado != DORMIDO) pend_n = pend | flancos;

    case (estado)
      IDLE: begin
        // A decay tick in the same cycle pushes arbitration one cycle later
        if ((pend != 3'b000) && !tick_decaimiento) begin
          for (int i = 0; i < 3; i++) begin
            if (!hallado && pend[cand]) begin
              hallado = 1'b1;
              ganador = cand;
            end
            cand = siguiente(cand);
          end
          if ((ganador == BOT_COMIDA) && (nivel == NIVEL_LLENO)) begin
            pend_n[BOT_COMIDA] = 1'b0;
            descartado_n       = 1'b1;
          end else begin
            estado_n = WAIT_ACK;
            conc_n   = ganador;
            valida_n = 1'b1;
            accion_n = codigo_accion(ganador);
          end
        end
      end
      WAIT_ACK: begin
        // Ack and timeout retire the grant the same way; only the next state
        // and the sticky error differ
        if (accion_listo || (to_cnt == TO_FIN)) begin
          pend_n[conc] = 1'b0;
          ptr_n        = siguiente(conc);
          valida_n     = 1'b0;
          accion_n     = ACC_NADA;
          to_n         = '0;
          if (accion_listo) begin
            estado_n = (conc == BOT_DORMIR) ? DORMIDO : IDLE;
          end else begin
            estado_n = IDLE;
            error_n  = 1'b1;
          end
        end else begin
          to_n = to_cnt + AW'(1);
        end
      end
      DORMIDO: begin
        if (tick_decaimiento) begin
          if (sl_cnt == SL_FIN) begin
            sl_n     = '0;
            estado_n = IDLE;
          end else begin
            sl_n = sl_cnt + SW'(1);
          end
        end
      end
      default: estado_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado        <= IDLE;
      pend          <= 3'b000;
      ptr           <= BOT_COMIDA;
      conc          <= BOT_COMIDA;
      sl_cnt        <= '0;
      to_cnt        <= '0;
      accion_valida <= 1'b0;
      accion        <= ACC_NADA;
      descartado    <= 1'b0;
      error_timeout <= 1'b0;
    end else begin
      estado        <= estado_n;
      pend          <= pend_n;
      ptr           <= ptr_n;
      conc          <= conc_n;
      sl_cnt        <= sl_n;
      to_cnt        <= to_n;
      accion_valida <= valida_n;
      accion        <= accion_n;
      descartado    <= descartado_n;
      error_timeout <= error_n;
    end
  end

endmodule

// File: tb/tb_planificador_acciones.sv
// Bench for planificador_acciones: a request-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_planificador_acciones;

  localparam int TICK_DIV    = 10;
  localparam int SLEEP_TICKS = 3;
  localparam int ACK_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       boton_comida = 1'b0;
  logic       boton_jugar = 1'b0;
  logic       boton_dormir = 1'b0;
  logic [1:0] nivel = 2'd1;
  logic       accion_listo = 1'b0;
  logic       accion_valida;
  logic [1:0] accion;
  logic       tick_decaimiento;
  logic       dormido;
  logic       descartado;
  logic       error_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit auto_ack = 1'b1;

  planificador_acciones #(
    .TICK_DIV(TICK_DIV), .SLEEP_TICKS(SLEEP_TICKS), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .boton_comida(boton_comida), .boton_jugar(boton_jugar), .boton_dormir(boton_dormir),
    .nivel(nivel), .accion_listo(accion_listo),
    .accion_valida(accion_valida), .accion(accion),
    .tick_decaimiento(tick_decaimiento), .dormido(dormido),
    .descartado(descartado), .error_timeout(error_timeout)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (request level) ----------------
  // mode: 0 waiting for requests, 1 action presented, 2 asleep
  int m_edges = 0, m_mode = 0, m_ptr = 0, m_gnt = 0, m_since = 0, m_sleep = 0;
  bit [2:0] m_pend = '0, h1 = '0, h2 = '0, h3 = '0;
  bit m_desc = 1'b0, m_err = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_edges = 0; m_mode = 0; m_ptr = 0; m_gnt = 0; m_since = 0; m_sleep = 0;
      m_pend = '0; h1 = '0; h2 = '0; h3 = '0; m_desc = 1'b0; m_err = 1'b0;
    end else begin
      bit tk;
      bit [2:0] arr, p;
      int w;
      tk  = (m_edges % TICK_DIV) == TICK_DIV - 1;
      arr = h2 & ~h3;  // a press is seen two edges after its first sample
      h3 = h2; h2 = h1; h1 = {boton_dormir, boton_jugar, boton_comida};
      p = (m_mode == 2) ? m_pend : (m_pend | arr);
      m_desc = 1'b0;
      case (m_mode)
        0: if (m_pend != 0 && !tk) begin
          w = -1;
          for (int i = 0; i < 3; i++)
            if (w < 0 && m_pend[(m_ptr + i) % 3]) w = (m_ptr + i) % 3;
          if (w == 0 && nivel == 2'd3) begin
            p[0] = 1'b0; m_desc = 1'b1;
          end else begin
            m_mode = 1; m_gnt = w; m_since = 0;
          end
        end
        1: begin
          if (!accion_listo) m_since++;
          if (accion_listo || m_since == ACK_TIMEOUT) begin
            p[m_gnt] = 1'b0;
            m_ptr = (m_gnt + 1) % 3;
            if (!accion_listo) m_err = 1'b1;
            m_mode = (accion_listo && m_gnt == 2) ? 2 : 0;
            m_sleep = 0;
          end
        end
        default: if (tk) begin
          m_sleep++;
          if (m_sleep == SLEEP_TICKS) m_mode = 0;
        end
      endcase
      m_pend = p;
      m_edges++;
    end
  end

  function automatic logic [6:0] modelo_salidas();
    logic [1:0] c;
    c = (m_mode == 1) ? 2'(m_gnt + 1) : 2'b00;
    return {m_mode == 1, c, (m_edges % TICK_DIV) == TICK_DIV - 1, m_mode == 2, m_desc, m_err};
  endfunction

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      logic [6:0] d, m;
      d = {accion_valida, accion, tick_decaimiento, dormido, descartado, error_timeout};
      m = modelo_salidas();
      n_tests++;
      if (d !== m) begin
        n_fail++;
        $display("FAIL ciclo t=%0t dut=%b modelo=%b (valida,accion,tick,dormido,desc,err)", $time, d, m);
      end
    end
  end

  // ---------------- pet FSM stand-in: ack 2 cycles after valid ----------------
  int vcnt = 0;
  initial forever begin
    @(negedge clk);
    if (reset || !accion_valida || !auto_ack) begin
      vcnt = 0;
      accion_listo = 1'b0;
    end else begin
      vcnt++;
      accion_listo = (vcnt == 2);
    end
  end

  // ---------------- observers feeding the directed checks ----------------
  logic [1:0] gq[$];
  int desc_cnt = 0, dtick_cnt = 0, last_run = 0, run = 0;
  bit prev_v = 1'b0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_v = 1'b0; run = 0;
    end else begin
      if (accion_valida) begin
        if (!prev_v) begin gq.push_back(accion); run = 0; end
        run++;
      end else if (prev_v) begin
        last_run = run;
      end
      prev_v = accion_valida;
      if (descartado) desc_cnt++;
      if (dormido && tick_decaimiento) dtick_cnt++;
    end
  end

  task automatic check(input string nombre, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s obtenido=%0d esperado=%0d", nombre, act, exp);
    end
  endtask

  task automatic pulsar(input logic [2:0] b);
    {boton_dormir, boton_jugar, boton_comida} = b;
    repeat (4) @(negedge clk);
    {boton_dormir, boton_jugar, boton_comida} = 3'b000;
  endtask

  task automatic esperar(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t simulacion sin terminar", $time);
    $fatal(1, "tiempo agotado");
  end

  initial begin
    int base, d0, n;
    // reset state
    repeat (3) @(negedge clk);
    check("reset_salidas", int'({accion_valida, accion, tick_decaimiento, dormido, descartado, error_timeout}), 0);
    reset = 1'b0;

    // T1: tick every TICK_DIV cycles, first one after 9 edges
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 9)  check("tick_k9", int'(tick_decaimiento), 1);
      if (k == 10) check("tick_k10", int'(tick_decaimiento), 0);
      if (k == 19) check("tick_k19", int'(tick_decaimiento), 1);
    end

    // T2: comida + jugar together -> 01 then 10
    nivel = 2'd1; base = gq.size();
    pulsar(3'b011); esperar(40);
    check("t2_num_grants", gq.size() - base, 2);
    check("t2_primera", int'(gq[base]), 1);
    check("t2_segunda", int'(gq[base + 1]), 2);

    // T3: comida discarded at full level, then jugar served
    nivel = 2'd3; base = gq.size(); d0 = desc_cnt;
    pulsar(3'b001); esperar(10);
    check("t3_descartes", desc_cnt - d0, 1);
    check("t3_sin_grant", gq.size() - base, 0);
    pulsar(3'b010); esperar(20);
    check("t3_jugar", int'(gq[base]), 2);

    // T4: dormir (pointer at dormir) wins over jugar; comida during sleep lost
    nivel = 2'd1; base = gq.size(); d0 = dtick_cnt;
    pulsar(3'b110);
    n = 0; while (!dormido && n < 60) begin @(negedge clk); n++; end
    check("t4_entra_dormido", int'(dormido), 1);
    pulsar(3'b001);
    n = 0; while (dormido && n < 100) begin @(negedge clk); n++; end
    check("t4_sale_dormido", int'(dormido), 0);
    esperar(30);
    check("t4_ticks_dormido", dtick_cnt - d0, 3);
    check("t4_num_grants", gq.size() - base, 2);
    check("t4_dormir", int'(gq[base]), 3);
    check("t4_jugar", int'(gq[base + 1]), 2);

    // T5: no ack -> grant dropped after 8 cycles, sticky error
    auto_ack = 1'b0; base = gq.size();
    pulsar(3'b010);
    n = 0; while (!accion_valida && n < 30) begin @(negedge clk); n++; end
    n = 0; while (accion_valida && n < 30) begin @(negedge clk); n++; end
    @(negedge clk);
    check("t5_duracion_valida", last_run, 8);
    check("t5_error", int'(error_timeout), 1);
    auto_ack = 1'b1;
    pulsar(3'b001); esperar(30);
    check("t5_error_fijo", int'(error_timeout), 1);
    check("t5_comida", int'(gq[base + 1]), 1);

    // T6: asynchronous reset in the middle of a handshake
    auto_ack = 1'b0;
    pulsar(3'b110);
    n = 0; while (!accion_valida && n < 30) begin @(negedge clk); n++; end
    check("t6_grant_jugar", int'(accion), 2);
    esperar(2);
    #3 reset = 1'b1;
    #1;
    check("t6_valida_reset", int'(accion_valida), 0);
    check("t6_accion_reset", int'(accion), 0);
    check("t6_error_reset", int'(error_timeout), 0);
    @(negedge clk);
    reset = 1'b0; auto_ack = 1'b1; base = gq.size();
    esperar(30);
    check("t6_pend_borrado", gq.size() - base, 0);
    pulsar(3'b011); esperar(40);
    check("t6_ptr_comida", int'(gq[base]), 1);
    check("t6_luego_jugar", int'(gq[base + 1]), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/planificador_acciones.md
Name: planificador_acciones

Overview:
- Sequencer/arbiter in front of the pet state machine, which consumes one action at a time plus a periodic decay tick.
- Synchronises the three user buttons (comida, jugar, dormir) and latches presses as pending requests.
- Grants pending requests round-robin over a valid/ready handshake, and generates the level-decay time base.
- Enforces a sleep lockout and discards feeding when the level is already full.

Parameters:
- TICK_DIV, 50000000, clk cycles per decay tick (minimum 2).
- SLEEP_TICKS, 4, decay ticks spent in sleep lockout after a granted dormir (minimum 1).
- ACK_TIMEOUT, 255, max cycles waiting for accion_listo before the grant is dropped.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- boton_comida  in  1  raw feed button, asynchronous, level.
- boton_jugar  in  1  raw play button, asynchronous, level.
- boton_dormir  in  1  raw sleep button, asynchronous, level.
- nivel  in  2  current hunger level from the pet FSM; 3 = full.
- accion_listo  in  1  pet FSM accepts the presented action.
- accion_valida  out  1  action presented.
- accion  out  2  action code: 01 comer, 10 jugar, 11 dormir. Value is 00 whenever accion_valida=0.
- tick_decaimiento  out  1  one-cycle decay pulse.
- dormido  out  1  high during sleep lockout.
- descartado  out  1  one-cycle pulse when a comida request is discarded because nivel is full.
- error_timeout  out  1  sticky; set on ack timeout, cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0; state IDLE; pending bits 0; round-robin pointer = comida.
  - Tick counter, sleep counter and timeout counter all 0.
  - Synchronizer flops cleared.
  - Reset asserted mid-handshake aborts the grant immediately.
- Input capture:
  - Each button passes through 2 sync flops, then a rising-edge detect.
  - A press sets its pending bit on the 3rd rising clk edge after the input rises.
  - A re-press while that bit is already set is ignored (one outstanding request per button).
- Decay tick:
  - Counter runs 0..TICK_DIV-1 in every state.
  - tick_decaimiento=1 in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- State IDLE:
  - Arbitration happens only when at least one bit is pending and tick_decaimiento=0 this cycle. A tick in the same cycle delays arbitration by one cycle.
  - Search order starts at the pointer: comida -> jugar -> dormir -> comida.
  - If the winner is comida and nivel==3: clear that bit, pulse descartado next cycle, stay IDLE, and do not move the pointer.
  - Otherwise go to WAIT_ACK. accion_valida/accion are registered and appear the cycle after selection.
- State WAIT_ACK:
  - accion and accion_valida are held stable.
  - On accion_listo=1 sampled at an edge:
    - clear the granted pending bit;
    - move the pointer to granted+1 (mod 3);
    - deassert accion_valida at that edge;
    - go to DORMIDO if the grant was dormir, otherwise IDLE.
  - Timeout counter increments each cycle without ack. On reaching ACK_TIMEOUT:
    - drop the grant and clear its pending bit;
    - set error_timeout;
    - move the pointer as for a normal ack;
    - go to IDLE.
  - accion_listo while accion_valida=0 is ignored.
- State DORMIDO:
  - dormido=1.
  - All new button edges are discarded and not latched; bits already pending stay pending.
  - Sleep counter increments on each tick_decaimiento.
  - After SLEEP_TICKS ticks: dormido=0, go to IDLE in the following cycle.

Decomposition:
- Shared package holds:
  - action codes: ACC_NADA=00, ACC_COMER=01, ACC_JUGAR=10, ACC_DORMIR=11;
  - state encodings IDLE/WAIT_ACK/DORMIDO;
  - NIVEL_LLENO=3.
- One sub-module, sincronizador_flanco: 2-flop synchronizer plus rising-edge pulse, with async active-high reset; instantiated once per button.
- Arbiter, tick counter and FSM remain in the top block.

Test Plan:
1. Bench parameters TICK_DIV=10, SLEEP_TICKS=3, ACK_TIMEOUT=8; after reset release -> tick_decaimiento pulses every 10 cycles; all other outputs 0.
2. Press comida and jugar simultaneously, nivel=1, ack 2 cycles after each valid -> accion=01 granted first, then 10; pointer ends at dormir.
3. Press comida with nivel=3 -> no accion_valida; descartado pulses once; a later jugar press is granted 10.
4. Press dormir, ack -> dormido=1 for exactly 3 ticks. A comida press during that window produces no grant after exit; a jugar press made before dormir is still granted after exit.
5. Grant jugar with accion_listo held 0 -> valid drops after 8 cycles; error_timeout=1 and stays set; a next press is still served.
6. Assert reset during WAIT_ACK, mid-cycle -> accion_valida=0 and pending bits cleared immediately, without waiting for an edge; the pointer is back at comida.
